// File: rtl/clock_display_scan_pkg.sv
// Shared constants for the HH:MM 7-segment scanner: segment patterns, digit slots, digit count.
// CLOCK_DISP_SECONDS_EN widens the scan to HH:MM:SS (six digits).
package clock_disp_pkg;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  localparam logic [2:0] DIG_HT = 3'd0;
  localparam logic [2:0] DIG_HU = 3'd1;
  localparam logic [2:0] DIG_MT = 3'd2;
  localparam logic [2:0] DIG_MU = 3'd3;
  localparam logic [2:0] DIG_ST = 3'd4;
  localparam logic [2:0] DIG_SU = 3'd5;

  function automatic int ndig();
`ifdef CLOCK_DISP_SECONDS_EN
    return 6;
`else
    return 4;
`endif
  endfunction

  localparam int NDIG = ndig();

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    if (d > 4'd9) return SEG_DASH;
    return SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/clock_display_scan_bin2bcd_60.sv
// Binary 0..59 to two BCD digits by compare-subtract; flags values above 59.
module bin2bcd_60 (
  input  logic [5:0] bin,
  output logic [2:0] tens,
  output logic [3:0] units,
  output logic       invalid
);

  always_comb begin
    invalid = (bin > 6'd59);
    tens    = 3'd0;
    units   = bin[3:0];
    if (bin >= 6'd50) begin
      tens  = 3'd5;
      units = 4'(bin - 6'd50);
    end else if (bin >= 6'd40) begin
      tens  = 3'd4;
      units = 4'(bin - 6'd40);
    end else if (bin >= 6'd30) begin
      tens  = 3'd3;
      units = 4'(bin - 6'd30);
    end else if (bin >= 6'd20) begin
      tens  = 3'd2;
      units = 4'(bin - 6'd20);
    end else if (bin >= 6'd10) begin
      tens  = 3'd1;
      units = 4'(bin - 6'd10);
    end
  end

endmodule

// File: rtl/clock_display_scan.sv
// Time-multiplexed HH:MM scanner for a 7-segment display with frame-synchronous input snapshot.
// Define CLOCK_DISP_SECONDS_EN to add the two seconds digits (HH:MM:SS).
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 1024,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [3:0]      hours,
  input  logic [5:0]      minutes,
  input  logic [5:0]      seconds,
  input  logic            am_pm,
  output logic [6:0]      seg,
  output logic            dp,
  output logic [NDIG-1:0] digit_sel
);

  localparam logic [15:0] CNT_LAST = 16'(REFRESH_DIV - 1);
  localparam logic [2:0]  IDX_LAST = 3'(NDIG - 1);
  localparam logic [6:0]  SEG_OFF  = {7{SEG_ACTIVE_LOW}};

  logic [15:0] refresh_cnt;
  logic [2:0]  digit_idx;
  logic [3:0]  snap_hr;
  logic [5:0]  snap_min;
  logic        snap_pm;
  logic        sec_even;

  logic [2:0] hr_tens, min_tens;
  logic [3:0] hr_units, min_units;
  logic       hr_inv, min_inv, hr_bad;
  logic [6:0] cur_seg;
  logic       cur_dp;

  bin2bcd_60 u_hr  (.bin({2'b00, snap_hr}), .tens(hr_tens),  .units(hr_units),  .invalid(hr_inv));
  bin2bcd_60 u_min (.bin(snap_min),         .tens(min_tens), .units(min_units), .invalid(min_inv));

  assign hr_bad = (snap_hr == 4'd0) || (snap_hr > 4'd12) || hr_inv;

`ifdef CLOCK_DISP_SECONDS_EN
  logic [5:0] snap_sec;
  logic [2:0] sec_tens;
  logic [3:0] sec_units;
  logic       sec_inv;
  bin2bcd_60 u_sec (.bin(snap_sec), .tens(sec_tens), .units(sec_units), .invalid(sec_inv));
  assign sec_even = ~snap_sec[0];
`else
  // Only the seconds LSB is kept: it drives the colon blink.
  logic snap_sec0;
  logic unused_sec;
  assign unused_sec = ^seconds[5:1];
  assign sec_even   = ~snap_sec0;
`endif

  always_comb begin
    cur_seg = SEG_BLANK;
    cur_dp  = 1'b0;
    case (digit_idx)
      DIG_HT: cur_seg = hr_bad ? SEG_DASH :
                        (hr_tens == 3'd0) ? SEG_BLANK : seg_of({1'b0, hr_tens});
      DIG_HU: begin
        cur_seg = hr_bad ? SEG_DASH : seg_of(hr_units);
        cur_dp  = sec_even;
      end
      DIG_MT: cur_seg = min_inv ? SEG_DASH : seg_of({1'b0, min_tens});
      DIG_MU: begin
        cur_seg = min_inv ? SEG_DASH : seg_of(min_units);
`ifdef CLOCK_DISP_SECONDS_EN
        cur_dp  = sec_even;
`else
        cur_dp  = snap_pm;
`endif
      end
`ifdef CLOCK_DISP_SECONDS_EN
      DIG_ST: cur_seg = sec_inv ? SEG_DASH : seg_of({1'b0, sec_tens});
      DIG_SU: begin
        cur_seg = sec_inv ? SEG_DASH : seg_of(sec_units);
        cur_dp  = snap_pm;
      end
`endif
      default: begin
        cur_seg = SEG_BLANK;
        cur_dp  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      snap_hr     <= 4'd12;
      snap_min    <= '0;
      snap_pm     <= 1'b0;
`ifdef CLOCK_DISP_SECONDS_EN
      snap_sec    <= '0;
`else
      snap_sec0   <= 1'b0;
`endif
      digit_sel   <= '0;
      seg         <= SEG_OFF;
      dp          <= SEG_ACTIVE_LOW;
    end else if (!ena) begin
      digit_sel <= '0;
      seg       <= SEG_OFF;
      dp        <= SEG_ACTIVE_LOW;
    end else begin
      // Digit is dark in the first and last cycle of its slot to avoid ghosting.
      digit_sel <= (refresh_cnt == '0 || refresh_cnt == CNT_LAST) ? '0 : NDIG'(1) << digit_idx;
      seg       <= cur_seg ^ SEG_OFF;
      dp        <= cur_dp ^ SEG_ACTIVE_LOW;
      if (refresh_cnt == CNT_LAST) begin
        refresh_cnt <= '0;
        if (digit_idx == IDX_LAST) begin
          digit_idx <= '0;
          snap_hr   <= hours;
          snap_min  <= minutes;
          snap_pm   <= am_pm;
`ifdef CLOCK_DISP_SECONDS_EN
          snap_sec  <= seconds;
`else
          snap_sec0 <= seconds[0];
`endif
        end else begin
          digit_idx <= digit_idx + 3'd1;
        end
      end else begin
        refresh_cnt <= refresh_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for the 4-digit HH:MM scanner with REFRESH_DIV=4 (16-cycle frame).
module tb_clock_display_scan;
  import clock_disp_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ena = 1'b1;
  logic [3:0]      hours = 4'd12;
  logic [5:0]      minutes = 6'd0;
  logic [5:0]      seconds = 6'd0;
  logic            am_pm = 1'b0;
  logic [6:0]      seg, seg_al;
  logic            dp, dp_al;
  logic [NDIG-1:0] sel, sel_al;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [6:0] P_BL = 7'b0000000;
  localparam logic [6:0] P_0  = 7'b0111111;
  localparam logic [6:0] P_1  = 7'b0000110;
  localparam logic [6:0] P_2  = 7'b1011011;
  localparam logic [6:0] P_3  = 7'b1001111;
  localparam logic [6:0] P_5  = 7'b1101101;
  localparam logic [6:0] P_7  = 7'b0000111;
  localparam logic [6:0] P_8  = 7'b1111111;
  localparam logic [6:0] P_9  = 7'b1101111;
  localparam logic [6:0] P_DA = 7'b1000000;

  always #5 clk = ~clk;

  clock_display_scan #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .ena(ena), .hours(hours), .minutes(minutes),
    .seconds(seconds), .am_pm(am_pm), .seg(seg), .dp(dp), .digit_sel(sel)
  );

  clock_display_scan #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .ena(ena), .hours(hours), .minutes(minutes),
    .seconds(seconds), .am_pm(am_pm), .seg(seg_al), .dp(dp_al), .digit_sel(sel_al)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [3:0] h, input logic [5:0] m, input logic [5:0] s,
                          input logic pm);
    hours = h; minutes = m; seconds = s; am_pm = pm;
  endtask

  // Runs one 16-cycle frame from a frame boundary and checks every output tick.
  task automatic scan_frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic p1,
                            input logic p3, input int chg_tick, input logic [5:0] chg_min);
    logic [6:0] es [4];
    logic       ep [4];
    logic [3:0] exp_sel;
    int slot, c;
    es = '{s0, s1, s2, s3};
    ep = '{1'b0, p1, 1'b0, p3};
    for (int i = 0; i < 16; i++) begin
      if (i == chg_tick) minutes = chg_min;
      tick();
      slot = i / 4;
      c = i % 4;
      exp_sel = (c == 1 || c == 2) ? (4'b0001 << slot) : 4'b0000;
      vectors++;
      if (sel !== exp_sel || sel_al !== exp_sel) begin
        miscompares++;
        $display("FAIL %s t%0d digit_sel got %b/%b exp %b", name, i, sel, sel_al, exp_sel);
      end
      if (c == 1) begin
        vectors++;
        if (seg !== es[slot] || dp !== ep[slot]) begin
          miscompares++;
          $display("FAIL %s idx%0d seg/dp got %b/%b exp %b/%b", name, slot, seg, dp,
                   es[slot], ep[slot]);
        end
        vectors++;
        if (seg_al !== ~es[slot] || dp_al !== ~ep[slot]) begin
          miscompares++;
          $display("FAIL %s idx%0d active-low seg/dp got %b/%b exp %b/%b", name, slot,
                   seg_al, dp_al, ~es[slot], ~ep[slot]);
        end
      end
    end
  endtask

  task automatic test_reset();
    set_time(4'd12, 6'd0, 6'd0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (sel !== 4'b0 || seg !== 7'b0 || dp !== 1'b0 ||
        sel_al !== 4'b0 || seg_al !== 7'b1111111 || dp_al !== 1'b1) begin
      miscompares++;
      $display("FAIL reset outputs got %b %b %b / %b %b %b", sel, seg, dp, sel_al, seg_al, dp_al);
    end
    rst = 1'b0;
    scan_frame("first_frame_1200am", P_1, P_2, P_0, P_0, 1'b1, 1'b0, -1, 6'd0);
  endtask

  task automatic test_0907pm();
    set_time(4'd9, 6'd7, 6'd4, 1'b1);
    scan_frame("hold_prev_frame", P_1, P_2, P_0, P_0, 1'b1, 1'b0, -1, 6'd0);
    scan_frame("t0907pm", P_BL, P_9, P_0, P_7, 1'b1, 1'b1, -1, 6'd0);
  endtask

  task automatic test_mid_frame_change();
    scan_frame("no_tear_07", P_BL, P_9, P_0, P_7, 1'b1, 1'b1, 5, 6'd8);
    scan_frame("next_frame_08", P_BL, P_9, P_0, P_8, 1'b1, 1'b1, -1, 6'd0);
  endtask

  task automatic test_digits();
    set_time(4'd1, 6'd30, 6'd31, 1'b0);
    scan_frame("pre_0130", P_BL, P_9, P_0, P_8, 1'b1, 1'b1, -1, 6'd0);
    scan_frame("t0130_odd_sec", P_BL, P_1, P_3, P_0, 1'b0, 1'b0, -1, 6'd0);
    set_time(4'd10, 6'd59, 6'd58, 1'b1);
    scan_frame("pre_1059", P_BL, P_1, P_3, P_0, 1'b0, 1'b0, -1, 6'd0);
    scan_frame("t1059pm", P_1, P_0, P_5, P_9, 1'b1, 1'b1, -1, 6'd0);
  endtask

  task automatic test_dash();
    set_time(4'd0, 6'd63, 6'd4, 1'b1);
    scan_frame("pre_dash0", P_1, P_0, P_5, P_9, 1'b1, 1'b1, -1, 6'd0);
    scan_frame("dash_h0_m63", P_DA, P_DA, P_DA, P_DA, 1'b1, 1'b1, -1, 6'd0);
    set_time(4'd13, 6'd60, 6'd3, 1'b0);
    scan_frame("pre_dash13", P_DA, P_DA, P_DA, P_DA, 1'b1, 1'b1, -1, 6'd0);
    scan_frame("dash_h13_m60", P_DA, P_DA, P_DA, P_DA, 1'b0, 1'b0, -1, 6'd0);
  endtask

  task automatic test_ena_hold();
    for (int i = 0; i < 6; i++) tick();
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (sel !== 4'b0 || seg !== 7'b0 || dp !== 1'b0 ||
          sel_al !== 4'b0 || seg_al !== 7'b1111111 || dp_al !== 1'b1) begin
        miscompares++;
        $display("FAIL ena_low c%0d got %b %b %b / %b %b %b", i, sel, seg, dp, sel_al, seg_al, dp_al);
      end
    end
    ena = 1'b1;
    tick();
    vectors++;
    if (sel !== 4'b0010 || seg !== P_DA || dp !== 1'b0) begin
      miscompares++;
      $display("FAIL ena_resume got %b %b %b exp 0010 %b 0", sel, seg, dp, P_DA);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 2) begin
        vectors++;
        if (sel !== 4'b0100) begin
          miscompares++;
          $display("FAIL ena_resume_next_slot got %b exp 0100", sel);
        end
      end
    end
    scan_frame("after_ena", P_DA, P_DA, P_DA, P_DA, 1'b0, 1'b0, -1, 6'd0);
  endtask

  task automatic test_rst_mid_frame();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (sel !== 4'b0 || seg !== 7'b0 || dp !== 1'b0 ||
        sel_al !== 4'b0 || seg_al !== 7'b1111111 || dp_al !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid got %b %b %b / %b %b %b", sel, seg, dp, sel_al, seg_al, dp_al);
    end
    rst = 1'b0;
    scan_frame("snapshot_reset_1200", P_1, P_2, P_0, P_0, 1'b1, 1'b0, -1, 6'd0);
    scan_frame("after_rst_capture", P_DA, P_DA, P_DA, P_DA, 1'b0, 1'b0, -1, 6'd0);
  endtask

  initial begin
    test_reset();
    test_0907pm();
    test_mid_frame_change();
    test_digits();
    test_dash();
    test_ena_hold();
    test_rst_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
